// File: rtl/gpio_irq.sv
// gpio_irq: Wishbone GPIO controller with edge-triggered interrupts.
//
// Purpose
//   Up to 32 GPIO pins on a 32-bit Wishbone slave. Pad inputs pass through
//   a synchroniser. The output register supports atomic set and clear.
//   Each pin can capture rising and/or falling edges into a write-1-to-clear
//   status register. A single registered level interrupt goes to the CPU.
//
// Ports
//   wb_clk, wb_rst_n     clock, synchronous active-low reset
//   wb_adr_i[2:0]        word register index
//                        0 IN, 1 OUT, 2 DIR, 3 OUT_SET, 4 OUT_CLR,
//                        5 RISE_EN, 6 FALL_EN, 7 STAT
//   wb_dat_i/wb_dat_o    write / read data (read data valid with ack)
//   wb_sel_i[3:0]        byte enables, applied to every write
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o   classic single-cycle handshake
//   wb_err_o, wb_rty_o   always 0
//   gpio_i               asynchronous pad inputs
//   gpio_o, gpio_dir_o   output data and drive enable (1 = drive)
//   irq_o                registered OR of STAT
module gpio_irq #(
    parameter int unsigned NGPIO       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] DIR_RESET   = '0
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    input  logic [NGPIO-1:0] gpio_i,
    output logic [NGPIO-1:0] gpio_o,
    output logic [NGPIO-1:0] gpio_dir_o,
    output logic             irq_o
);

    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

    logic [NGPIO-1:0] sync_q [SYNC_STAGES];
    logic [NGPIO-1:0] prev_q;
    logic [NGPIO-1:0] rise_en_q;
    logic [NGPIO-1:0] fall_en_q;
    logic [NGPIO-1:0] stat_q;
    logic [ARM_W-1:0] arm_cnt;

    logic             req;
    logic             wr;
    logic             armed;
    logic [31:0]      byte_mask;
    logic [NGPIO-1:0] wmask;
    logic [NGPIO-1:0] wdat;
    logic [NGPIO-1:0] sync_v;
    logic [NGPIO-1:0] rise;
    logic [NGPIO-1:0] fall;
    logic [NGPIO-1:0] w1c;
    logic [NGPIO-1:0] stat_next;
    logic [31:0]      rdata;

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    always_comb begin
        // A request is not sampled while its ack is being presented, so a
        // held request acks every second cycle.
        req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
        wr        = req & wb_we_i;
        byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                     {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wmask     = byte_mask[NGPIO-1:0];
        wdat      = wb_dat_i[NGPIO-1:0] & wmask;
        sync_v    = sync_q[SYNC_STAGES-1];

        // Edge detection stays masked until the synchroniser and prev
        // register hold real pad data, so pins already high at reset
        // release do not look like rising edges.
        armed     = (arm_cnt == ARM_W'(ARM_MAX));
        rise      = sync_v & ~prev_q & rise_en_q & {NGPIO{armed}};
        fall      = ~sync_v & prev_q & fall_en_q & {NGPIO{armed}};

        w1c       = (wr && wb_adr_i == 3'd7) ? wdat : '0;
        // New edges are OR-ed in after the clear, so a set wins over a
        // simultaneous write-1-to-clear on the same bit.
        stat_next = (stat_q & ~w1c) | rise | fall;
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            3'd0:    rdata[NGPIO-1:0] = sync_v;
            3'd1:    rdata[NGPIO-1:0] = gpio_o;
            3'd2:    rdata[NGPIO-1:0] = gpio_dir_o;
            3'd5:    rdata[NGPIO-1:0] = rise_en_q;
            3'd6:    rdata[NGPIO-1:0] = fall_en_q;
            3'd7:    rdata[NGPIO-1:0] = stat_q;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            gpio_o     <= '0;
            gpio_dir_o <= DIR_RESET[NGPIO-1:0];
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            stat_q     <= '0;
            arm_cnt    <= '0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            irq_o      <= 1'b0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_v;

            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end

            stat_q   <= stat_next;
            irq_o    <= |stat_q;
            wb_ack_o <= req;

            if (req && !wb_we_i) begin
                wb_dat_o <= rdata;
            end

            if (wr) begin
                case (wb_adr_i)
                    3'd1:    gpio_o     <= (gpio_o & ~wmask) | wdat;
                    3'd2:    gpio_dir_o <= (gpio_dir_o & ~wmask) | wdat;
                    3'd3:    gpio_o     <= gpio_o | wdat;
                    3'd4:    gpio_o     <= gpio_o & ~wdat;
                    3'd5:    rise_en_q  <= (rise_en_q & ~wmask) | wdat;
                    3'd6:    fall_en_q  <= (fall_en_q & ~wmask) | wdat;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
Parametrised Wishbone GPIO controller, successor to the 8-bit GPIO. Supports NGPIO pins up to 32 on a 32-bit Wishbone slave. Adds:
- input synchroniser
- atomic set/clear of the output register
- per-pin rising/falling edge interrupt capture with write-1-to-clear status
- a single level interrupt output to the CPU interrupt controller

Parameters:
NGPIO, 32, number of pins (1..32); register bits [31:NGPIO] read 0, writes ignored
SYNC_STAGES, 2, input synchroniser depth (>=2)
DIR_RESET, 0, reset value of direction register (NGPIO bits, 1 = output)

Ports:
wb_clk  in  1  system clock
wb_rst_n  in  1  synchronous active-low reset
wb_adr_i  in  3  word register index
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables; a write updates only enabled bytes
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data, valid with ack
wb_ack_o  out  1  single-cycle acknowledge
wb_err_o  out  1  tied 0
wb_rty_o  out  1  tied 0
gpio_i  in  NGPIO  asynchronous pad inputs
gpio_o  out  NGPIO  output data
gpio_dir_o  out  NGPIO  direction, 1 = drive
irq_o  out  1  registered OR of (IRQ_STAT)

Behaviour:
- One clock domain: wb_clk. Reset is synchronous and active-low (wb_rst_n sampled on posedge wb_clk).
- Reset values:
  - gpio_o = 0, gpio_dir_o = DIR_RESET
  - RISE_EN = FALL_EN = STAT = 0
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0
  - synchroniser and previous-value registers = 0
- Register map (wb_adr_i):
  - 0 IN: read synchronised input; write ignored
  - 1 OUT: R/W gpio_o
  - 2 DIR: R/W gpio_dir_o
  - 3 OUT_SET: write 1s set OUT bits; reads 0
  - 4 OUT_CLR: write 1s clear OUT bits; reads 0
  - 5 RISE_EN: R/W
  - 6 FALL_EN: R/W
  - 7 STAT: read pending; write-1-to-clear
- Handshake:
  - A request is cyc&stb&!ack at a posedge. The next cycle wb_ack_o = 1 for exactly one cycle, then 0.
  - A held request therefore acks every second cycle.
  - Write side effects commit on the same edge that raises ack.
  - wb_dat_o is loaded on that edge for reads; it holds its value otherwise.
  - Requests during the ack cycle are not sampled.
- Synchroniser: gpio_i passes through SYNC_STAGES flops to give sync. A prev register holds sync delayed by 1.
  - rise = sync & ~prev & RISE_EN
  - fall = ~sync & prev & FALL_EN
- Edge-detect arming: edge detection is masked until an arm counter reaches SYNC_STAGES+1 cycles after reset release. Pins high at reset therefore raise no spurious rise.
- STAT update per bit: next = (STAT & ~w1c) | rise | fall. A set and a W1C on the same bit in the same cycle: set wins (bit stays 1).
- Latency:
  - gpio_i transition (stable across a clock edge) to STAT bit set: SYNC_STAGES+1 cycles
  - STAT to irq_o: +1 cycle
  - CPU W1C clearing the last bit: irq_o low 1 cycle after the ack edge
- Enable changes: disabling RISE_EN/FALL_EN does not clear already-pending STAT bits.
- Write priority: OUT, OUT_SET and OUT_CLR are distinct addresses, so only one can be written per access.
- Byte enables: wb_sel_i masks every write, including W1C and SET/CLR. A masked byte has no effect.
- gpio_dir_o does not gate IN: IN always reflects the pad, including pins currently driven.
- Reset mid-transaction: ack is dropped, no register commits, and the arm counter restarts.

Test Plan:
- Reset with NGPIO=32, DIR_RESET=0 → all outputs 0. Read addr 2 → 0x00000000, ack exactly 1 cycle after request.
- Write OUT=0x0000F0F0, OUT_SET=0x0000000F, OUT_CLR=0x000000F0, then read addr 1 → 0x0000F00F; gpio_o matches after each ack.
- Write DIR=0xFFFFFFFF with wb_sel_i=4'b0001 → reads 0x000000FF.
- RISE_EN=0x1, gpio_i[0] 0→1:
  - STAT[0] set 3 cycles later and irq_o 4 cycles later (SYNC_STAGES=2)
  - write STAT=0x1 → irq_o low the cycle after ack
  - a falling edge with FALL_EN=0 does not set STAT.
- Simultaneous rise on pin 3 and W1C of bit 3 in the same cycle → STAT[3] remains 1, irq_o stays high.
- Hold gpio_i=0xFFFFFFFF through reset with RISE_EN=all → STAT stays 0 after reset release. NGPIO=8 build: write IN/OUT 0xFFFFFFFF → OUT reads 0x000000FF.
